// File: rtl/multiexp_scalar_slicer_if.sv
// Scalar/point/beat bundle between the slicer and its neighbours.
// Ports: scalar stream (i_scl_*), point stream (i_pt_*), beat stream (o_dat_*, o_val, i_rdy).
// Directions are named from the slicer's side; slave = slicer, master = feeder/consumer.
interface multiexp_scalar_slicer_if #(
    parameter int SCALAR_W = 256,
    parameter int POINT_W  = 512,
    parameter int WINDOW_W = 4
);
    localparam int NWIN  = SCALAR_W / WINDOW_W;
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic [SCALAR_W-1:0] i_scl_dat;
    logic                i_scl_val;
    logic                i_scl_last;
    logic                o_scl_rdy;
    logic [POINT_W-1:0]  i_pt_dat;
    logic                i_pt_val;
    logic                i_pt_last;
    logic                o_pt_rdy;
    logic [WINDOW_W-1:0] o_dat_digit;
    logic [WIN_W-1:0]    o_dat_win;
    logic [POINT_W-1:0]  o_dat_pt;
    logic                o_dat_last;
    logic                o_val;
    logic                i_rdy;

    modport slave (
        input  i_scl_dat, i_scl_val, i_scl_last, i_pt_dat, i_pt_val, i_pt_last, i_rdy,
        output o_scl_rdy, o_pt_rdy, o_dat_digit, o_dat_win, o_dat_pt, o_dat_last, o_val
    );

    modport master (
        output i_scl_dat, i_scl_val, i_scl_last, i_pt_dat, i_pt_val, i_pt_last, i_rdy,
        input  o_scl_rdy, o_pt_rdy, o_dat_digit, o_dat_win, o_dat_pt, o_dat_last, o_val
    );
endinterface

// File: rtl/multiexp_scalar_slicer.sv
// Pairs scalar and point streams and slices each scalar into WINDOW_W digits, one beat per window.
// Latency: first beat valid the cycle after pair acceptance; one beat/cycle; 1-cycle bubble between pairs.
// Backpressure: beat register holds while o_val && !i_rdy; pairs accepted only in IDLE with both valids.
// Ports: i_clk/i_rst (async, active high), s (slave modport: scalar, point and beat streams),
//        i_clr (sync clear of counter/error), o_pair_cnt (pairs accepted), o_err (sticky last mismatch).
module multiexp_scalar_slicer #(
    parameter int SCALAR_W  = 256,
    parameter int POINT_W   = 512,
    parameter int WINDOW_W  = 4,
    parameter int SKIP_ZERO = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    multiexp_scalar_slicer_if.slave s,
    output logic [31:0] o_pair_cnt,
    output logic        o_err
);
    localparam int NWIN  = SCALAR_W / WINDOW_W;
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SCALAR_W-1:0] scl_q;
    logic [POINT_W-1:0]  pt_q;
    logic                last_q;
    logic [NWIN-1:0]     pend_q;
    logic                oval_q;
    logic [WINDOW_W-1:0] digit_q;
    logic [WIN_W-1:0]    win_q;
    logic [POINT_W-1:0]  opt_q;
    logic                olast_q;
    logic [31:0]         cnt_q;
    logic                err_q;

    logic                accept;
    logic                out_free;
    logic                step;
    logic [NWIN-1:0]     in_mask;
    logic [NWIN-1:0]     src_mask;
    logic [NWIN-1:0]     rem_mask;
    logic [SCALAR_W-1:0] src_scl;
    logic [POINT_W-1:0]  src_pt;
    logic                src_last;
    logic [WIN_W-1:0]    sel_w;
    logic                sel_any;
    logic [WINDOW_W-1:0] sel_digit;

    // Windows that must produce a beat for the incoming pair. The top window of a
    // last pair stays eligible so the terminating beat always reaches downstream.
    always_comb begin
        in_mask = '0;
        for (int w = 0; w < NWIN; w++) begin
            in_mask[w] = (SKIP_ZERO == 0)
                      || (s.i_scl_dat[w*WINDOW_W +: WINDOW_W] != '0)
                      || (s.i_scl_last && (w == NWIN - 1));
        end
    end

    // In IDLE the first beat is taken straight from the inputs so it can load on the
    // acceptance edge; in EMIT it comes from the registered pair.
    assign src_mask = (state_q == IDLE) ? in_mask        : pend_q;
    assign src_scl  = (state_q == IDLE) ? s.i_scl_dat    : scl_q;
    assign src_pt   = (state_q == IDLE) ? s.i_pt_dat     : pt_q;
    assign src_last = (state_q == IDLE) ? s.i_scl_last   : last_q;

    // Lowest pending window wins; skipped windows therefore cost no cycles.
    always_comb begin
        sel_w   = '0;
        sel_any = 1'b0;
        for (int w = NWIN - 1; w >= 0; w--) begin
            if (src_mask[w]) begin
                sel_w   = WIN_W'(w);
                sel_any = 1'b1;
            end
        end
        rem_mask        = src_mask;
        rem_mask[sel_w] = 1'b0;
    end

    assign sel_digit = WINDOW_W'(src_scl >> (sel_w * WINDOW_W));

    assign out_free = !oval_q || s.i_rdy;
    assign step     = accept || ((state_q == EMIT) && out_free);

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state. EMIT ends once nothing is pending and the beat slot drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EMIT;
            EMIT:    if (out_free && !sel_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Both streams are accepted together or not at all.
    always_comb begin
        accept = 1'b0;
        if ((state_q == IDLE) && !i_rst) accept = s.i_scl_val && s.i_pt_val;
    end

    assign s.o_scl_rdy = accept;
    assign s.o_pt_rdy  = accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_q   <= '0;
            pt_q    <= '0;
            last_q  <= 1'b0;
            pend_q  <= '0;
            oval_q  <= 1'b0;
            digit_q <= '0;
            win_q   <= '0;
            opt_q   <= '0;
            olast_q <= 1'b0;
        end else begin
            if (accept) begin
                scl_q  <= s.i_scl_dat;
                pt_q   <= s.i_pt_dat;
                last_q <= s.i_scl_last;
            end
            if (step) begin
                pend_q <= rem_mask;
                oval_q <= sel_any;
                if (sel_any) begin
                    digit_q <= sel_digit;
                    win_q   <= sel_w;
                    opt_q   <= src_pt;
                    olast_q <= src_last && (rem_mask == '0);
                end
            end
        end
    end

    // A clear coinciding with an acceptance still counts that pair.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (i_clr) begin
            cnt_q <= {31'b0, accept};
            err_q <= accept && (s.i_scl_last != s.i_pt_last);
        end else begin
            if (accept) cnt_q <= cnt_q + 32'd1;
            if (accept && (s.i_scl_last != s.i_pt_last)) err_q <= 1'b1;
        end
    end

    assign s.o_val       = oval_q;
    assign s.o_dat_digit = digit_q;
    assign s.o_dat_win   = win_q;
    assign s.o_dat_pt    = opt_q;
    assign s.o_dat_last  = olast_q;
    assign o_pair_cnt    = cnt_q;
    assign o_err         = err_q;
endmodule

// File: tb/tb_multiexp_scalar_slicer.sv
`timescale 1ns/1ps
module tb_multiexp_scalar_slicer;
    localparam int SCALAR_W = 256;
    localparam int POINT_W  = 512;
    localparam int WINDOW_W = 4;
    localparam int NWIN     = SCALAR_W / WINDOW_W;
    localparam int WIN_W    = 6;

    typedef struct packed {
        logic [WINDOW_W-1:0] digit;
        logic [WIN_W-1:0]    win;
        logic                last;
        logic [POINT_W-1:0]  pt;
    } beat_t;

    logic clk, rst;
    logic [1:0]               clr;
    logic [1:0][SCALAR_W-1:0] scl_dat;
    logic [1:0]               scl_val, scl_last, pt_val, pt_last, rdy;
    logic [1:0][POINT_W-1:0]  pt_dat;
    logic [1:0]               scl_rdy, pt_rdy, o_val, dat_last, err;
    logic [1:0][WINDOW_W-1:0] dig;
    logic [1:0][WIN_W-1:0]    win;
    logic [1:0][POINT_W-1:0]  dpt;
    logic [1:0][31:0]         cnt;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q [2][$];
    beat_t held [2];
    int    beats_seen [2];
    int    cnt_m [2];
    bit    err_m [2], stall_p [2], acc_p [2], acc_ne [2];
    int    rdy_mode [2];
    bit    rand_clr [2];
    int    pat_cnt = 0;

    // Instance 0 emits every window, instance 1 skips zero digits.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        multiexp_scalar_slicer_if #(.SCALAR_W(SCALAR_W), .POINT_W(POINT_W), .WINDOW_W(WINDOW_W)) bus ();
        assign bus.i_scl_dat  = scl_dat[g];
        assign bus.i_scl_val  = scl_val[g];
        assign bus.i_scl_last = scl_last[g];
        assign bus.i_pt_dat   = pt_dat[g];
        assign bus.i_pt_val   = pt_val[g];
        assign bus.i_pt_last  = pt_last[g];
        assign bus.i_rdy      = rdy[g];
        assign scl_rdy[g]     = bus.o_scl_rdy;
        assign pt_rdy[g]      = bus.o_pt_rdy;
        assign o_val[g]       = bus.o_val;
        assign dig[g]         = bus.o_dat_digit;
        assign win[g]         = bus.o_dat_win;
        assign dpt[g]         = bus.o_dat_pt;
        assign dat_last[g]    = bus.o_dat_last;
        multiexp_scalar_slicer #(
            .SCALAR_W(SCALAR_W), .POINT_W(POINT_W), .WINDOW_W(WINDOW_W), .SKIP_ZERO(g)
        ) dut (
            .i_clk(clk), .i_rst(rst), .i_clr(clr[g]), .s(bus),
            .o_pair_cnt(cnt[g]), .o_err(err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [599:0] got, input logic [599:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [POINT_W-1:0] rand_pt();
        logic [POINT_W-1:0] p;
        for (int i = 0; i < POINT_W / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [SCALAR_W-1:0] rand_scl(input int dens);
        logic [SCALAR_W-1:0] v = '0;
        for (int i = 0; i < NWIN; i++)
            if ($urandom_range(0, 99) < dens) v[i*WINDOW_W +: WINDOW_W] = 4'($urandom_range(1, 15));
        return v;
    endfunction

    // Downstream ready patterns: 0 always ready, 1 random, 2 repeating 1,0,0.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rdy_mode[d])
                1:       rdy[d] = 1'($urandom_range(0, 1));
                2:       rdy[d] = (pat_cnt % 3 == 0);
                default: rdy[d] = 1'b1;
            endcase
            if (rand_clr[d]) clr[d] = ($urandom_range(0, 15) == 0);
        end
        pat_cnt++;
    end

    // Reference model: every accepted pair expands into its list of beats, taken
    // straight from the windowing rules; the monitor pops one per accepted beat.
    always @(negedge clk) begin
        beat_t e, cur;
        logic [WINDOW_W-1:0] dg;
        bit acc, mism;
        int n;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_q[d].delete();
                cnt_m[d] = 0; err_m[d] = 0; stall_p[d] = 0; acc_p[d] = 0; acc_ne[d] = 0;
            end else begin
                cur = '{digit: dig[d], win: win[d], last: dat_last[d], pt: dpt[d]};
                chk($sformatf("d%0d_pair_cnt", d), cnt[d], cnt_m[d]);
                chk($sformatf("d%0d_err", d), err[d], err_m[d]);
                chk($sformatf("d%0d_rdy_same", d), scl_rdy[d], pt_rdy[d]);
                if (scl_rdy[d]) chk($sformatf("d%0d_rdy_needs_both", d), scl_val[d] & pt_val[d], 1);
                if (acc_p[d]) chk($sformatf("d%0d_first_latency", d), o_val[d], acc_ne[d]);
                if (stall_p[d]) begin
                    chk($sformatf("d%0d_stall_val", d), o_val[d], 1);
                    chk($sformatf("d%0d_stall_hold", d), cur, held[d]);
                end
                if (o_val[d] && rdy[d]) begin
                    chk($sformatf("d%0d_beat_expected", d), exp_q[d].size() > 0, 1);
                    if (exp_q[d].size() > 0) begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("d%0d_digit", d), cur.digit, e.digit);
                        chk($sformatf("d%0d_win", d), cur.win, e.win);
                        chk($sformatf("d%0d_last", d), cur.last, e.last);
                        chk($sformatf("d%0d_point", d), cur.pt, e.pt);
                        beats_seen[d]++;
                    end
                end
                acc  = scl_rdy[d];
                mism = (scl_last[d] != pt_last[d]);
                n = 0;
                if (acc) begin
                    chk($sformatf("d%0d_pair_overlap", d), exp_q[d].size(), 0);
                    for (int w = 0; w < NWIN; w++) begin
                        dg = WINDOW_W'((scl_dat[d] / (256'd1 << (w * WINDOW_W))) % 16);
                        if (d == 0 || dg != 0 || (scl_last[d] && w == NWIN - 1)) begin
                            exp_q[d].push_back('{digit: dg, win: WIN_W'(w),
                                                 last: scl_last[d] && (w == NWIN - 1), pt: pt_dat[d]});
                            n++;
                        end
                    end
                end
                if (clr[d]) begin
                    cnt_m[d] = acc ? 1 : 0;
                    err_m[d] = acc && mism;
                end else begin
                    cnt_m[d] += acc ? 1 : 0;
                    err_m[d] = err_m[d] | (acc && mism);
                end
                stall_p[d] = o_val[d] && !rdy[d];
                held[d]    = cur;
                acc_p[d]   = acc;
                acc_ne[d]  = (n > 0);
            end
        end
    end

    task automatic send(input int d, input logic [SCALAR_W-1:0] s, input bit sl, input bit pl, input int skew);
        bit got = 0;
        pt_dat[d]  = rand_pt();
        pt_last[d] = pl;
        if (skew > 0) begin
            pt_val[d] = 1'b1;
            for (int k = 0; k < skew; k++) begin
                @(negedge clk);
                chk("skew_no_rdy", {scl_rdy[d], pt_rdy[d]}, 0);
                tick();
            end
        end
        scl_dat[d] = s; scl_last[d] = sl; scl_val[d] = 1'b1; pt_val[d] = 1'b1;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk);
            got = scl_rdy[d];
        end
        chk("accept_timeout", got, 1);
        tick();
        scl_val[d] = 1'b0; pt_val[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit done = 0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk);
            done = (exp_q[d].size() == 0) && !o_val[d];
        end
        chk("drain_timeout", done, 1);
        tick();
    endtask

    initial begin
        int b;
        bit sl, pl;
        int dens [4] = '{0, 5, 30, 100};
        rst = 1'b0; clr = '0; scl_dat = '0; scl_val = '0; scl_last = '0;
        pt_dat = '0; pt_val = '0; pt_last = '0; rdy = '1;
        rdy_mode = '{0, 0}; rand_clr = '{0, 0}; beats_seen = '{0, 0};
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_val", o_val[d], 0);
            chk("rst_scl_rdy", scl_rdy[d], 0);
            chk("rst_pt_rdy", pt_rdy[d], 0);
            chk("rst_digit", dig[d], 0);
            chk("rst_win", win[d], 0);
            chk("rst_pt", dpt[d], 0);
            chk("rst_last", dat_last[d], 0);
            chk("rst_cnt", cnt[d], 0);
            chk("rst_err", err[d], 0);
        end
        tick();
        rst = 1'b0;
        tick();

        // Full window sweep without skipping.
        b = beats_seen[0];
        send(0, 256'h21, 0, 0, 0);
        drain(0);
        chk("t1_beats", beats_seen[0] - b, 64);
        chk("t1_cnt", cnt[0], 1);

        // Skipping with a forced final window.
        b = beats_seen[1];
        send(1, 256'h21, 1, 1, 0);
        drain(1);
        chk("t2_beats", beats_seen[1] - b, 3);

        // All-zero non-last pair, then only the top digit set.
        b = beats_seen[1];
        send(1, '0, 0, 0, 0);
        drain(1);
        chk("t3_zero_beats", beats_seen[1] - b, 0);
        send(1, {4'hF, 252'b0}, 1, 1, 0);
        drain(1);
        chk("t3_top_beats", beats_seen[1] - b, 1);

        // Stalls from downstream.
        rdy_mode[1] = 2;
        b = beats_seen[1];
        send(1, 256'h4321, 0, 0, 0);
        drain(1);
        chk("t4_beats", beats_seen[1] - b, 4);
        rdy_mode[1] = 0;

        // Point valid arrives well before the scalar.
        send(1, 256'h5, 0, 0, 5);
        drain(1);

        // Last-flag mismatch, then clear.
        send(1, 256'h30, 1, 0, 0);
        drain(1);
        chk("mism_err", err[1], 1);
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        @(negedge clk);
        chk("clr_err", err[1], 0);
        chk("clr_cnt", cnt[1], 0);
        tick();

        // Reset while emitting; the next pair must restart at window 0.
        send(1, {64{4'h7}}, 0, 0, 0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_val", o_val[1], 0);
        chk("rst_mid_digit", dig[1], 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        b = beats_seen[1];
        send(1, 256'h5, 1, 1, 0);
        drain(1);
        chk("post_rst_beats", beats_seen[1] - b, 2);

        // Randomised traffic with random stalls, clears, skew and mismatches.
        rdy_mode = '{1, 1};
        rand_clr[1] = 1;
        for (int i = 0; i < 40; i++) begin
            sl = ($urandom_range(0, 2) == 0);
            pl = ($urandom_range(0, 7) == 0) ? !sl : sl;
            send(1, rand_scl(dens[$urandom_range(0, 3)]), sl, pl, $urandom_range(0, 2));
        end
        drain(1);
        rand_clr[1] = 0;
        clr[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sl = ($urandom_range(0, 1) == 0);
            send(0, rand_scl(dens[$urandom_range(0, 3)]), sl, sl, $urandom_range(0, 1));
        end
        drain(0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
